// File: rtl/paint_pkg.sv
// Shared constants for the paint pipeline: scan FSM encoding, brush radii and
// the colour codes used by the stamper (mirrors colors.svh).
package paint_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] STAMP = 2'd1;
   localparam logic [1:0] CLEAR = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // cmd_size is the brush radius; these name the resulting square edge
   localparam logic [1:0] R1 = 2'd0;
   localparam logic [1:0] R3 = 2'd1;
   localparam logic [1:0] R5 = 2'd2;
   localparam logic [1:0] R7 = 2'd3;

   localparam logic [2:0] COLOR_BLUE  = 3'b001;
   localparam logic [2:0] COLOR_GREEN = 3'b010;
   localparam logic [2:0] COLOR_RED   = 3'b100;
   localparam logic [2:0] ERASE_COLOR = 3'b111;

endpackage

// File: rtl/clip_range.sv
// Clips one axis of a brush footprint, centre +/- r, to the canvas.
// Pure combinational; the top instantiates one per axis.
module clip_range #(
   parameter int CANVAS_MAX = 128,
   parameter int CW         = 8
) (
   input  logic [CW-1:0] centre,
   input  logic [1:0]    r,
   output logic [CW-1:0] lo,
   output logic [CW-1:0] hi,
   output logic          empty
);

   localparam int SW = CW + 2;
   localparam logic signed [SW-1:0] MAX_S = SW'(CANVAS_MAX - 1);

   logic signed [SW-1:0] c_s;
   logic signed [SW-1:0] r_s;
   logic signed [SW-2+1:0] lo_raw;
   logic signed [SW-1:0] hi_raw;
   logic signed [SW-1:0] lo_s;
   logic signed [SW-1:0] hi_s;

   // Two guard bits keep centre-r below zero and centre+r above the canvas
   // representable, so the clamps see the true value.
   always_comb begin
      c_s    = $signed({2'b00, centre});
      r_s    = $signed({{CW{1'b0}}, r});
      lo_raw = c_s - r_s;
      hi_raw = c_s + r_s;
      lo_s   = lo_raw;
      hi_s   = hi_raw;
      if (lo_raw[SW-1]) begin
         lo_s = '0;
      end
      if (hi_raw > MAX_S) begin
         hi_s = MAX_S;
      end
      empty = (c_s > MAX_S) || (lo_s > hi_s);
      lo    = lo_s[CW-1:0];
      hi    = hi_s[CW-1:0];
   end

endmodule

// File: rtl/brush_stamper.sv
// Turns paint commands into a one-pixel-per-clock write stream for pixelStore,
// either a clipped square brush stamp or a full-canvas erase.
module brush_stamper
   import paint_pkg::*;
#(
   parameter int CANVAS_MAX = 128,
   parameter int CW         = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_clear,
   input  logic [CW-1:0] cmd_cx,
   input  logic [CW-1:0] cmd_cy,
   input  logic [1:0]    cmd_size,
   input  logic [2:0]    cmd_color,
   output logic          brush,
   output logic [CW-1:0] wx,
   output logic [CW-1:0] wy,
   output logic [2:0]    newColor,
   output logic          done
);

   localparam logic [CW-1:0] MAX_COORD = CW'(CANVAS_MAX - 1);

   logic [1:0]    state;
   logic [CW-1:0] x_lo;
   logic [CW-1:0] x_hi;
   logic [CW-1:0] y_hi;

   logic [CW-1:0] clip_x_lo;
   logic [CW-1:0] clip_x_hi;
   logic [CW-1:0] clip_y_lo;
   logic [CW-1:0] clip_y_hi;
   logic          clip_x_empty;
   logic          clip_y_empty;

   logic          transfer;
   logic          last_col;
   logic          last_pix;

   clip_range #(.CANVAS_MAX(CANVAS_MAX), .CW(CW)) u_clip_x (
      .centre (cmd_cx),
      .r      (cmd_size),
      .lo     (clip_x_lo),
      .hi     (clip_x_hi),
      .empty  (clip_x_empty)
   );

   clip_range #(.CANVAS_MAX(CANVAS_MAX), .CW(CW)) u_clip_y (
      .centre (cmd_cy),
      .r      (cmd_size),
      .lo     (clip_y_lo),
      .hi     (clip_y_hi),
      .empty  (clip_y_empty)
   );

   // cmd_ready is only ever high in IDLE, so it doubles as the idle qualifier
   assign transfer = cmd_valid && cmd_ready;

   // wx/wy are the scan counters themselves: they always show the pixel
   // currently being written.
   assign last_col = (wx == x_hi);
   assign last_pix = last_col && (wy == y_hi);

   // STAMP and CLEAR share one raster walker; a clear is just a stamp whose
   // window is the whole canvas in the erase colour.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         brush     <= 1'b0;
         wx        <= '0;
         wy        <= '0;
         newColor  <= ERASE_COLOR;
         done      <= 1'b0;
         x_lo      <= '0;
         x_hi      <= '0;
         y_hi      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (transfer) begin
                  cmd_ready <= 1'b0;
                  if (cmd_clear) begin
                     state    <= CLEAR;
                     brush    <= 1'b1;
                     wx       <= '0;
                     wy       <= '0;
                     x_lo     <= '0;
                     x_hi     <= MAX_COORD;
                     y_hi     <= MAX_COORD;
                     newColor <= ERASE_COLOR;
                  end else if (clip_x_empty || clip_y_empty) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= STAMP;
                     brush    <= 1'b1;
                     wx       <= clip_x_lo;
                     wy       <= clip_y_lo;
                     x_lo     <= clip_x_lo;
                     x_hi     <= clip_x_hi;
                     y_hi     <= clip_y_hi;
                     newColor <= cmd_color;
                  end
               end
            end
            STAMP, CLEAR: begin
               if (last_pix) begin
                  state <= DONE;
                  brush <= 1'b0;
                  done  <= 1'b1;
               end else if (last_col) begin
                  wx <= x_lo;
                  wy <= wy + 1'b1;
               end else begin
                  wx <= wx + 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               brush     <= 1'b0;
               done      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_brush_stamper.sv
// Directed bench for brush_stamper: hand-computed clip windows, raster order,
// done timing, handshake and a 128x128 reference canvas.
module tb_brush_stamper;
   import paint_pkg::*;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_clear;
   logic [7:0] cmd_cx;
   logic [7:0] cmd_cy;
   logic [1:0] cmd_size;
   logic [2:0] cmd_color;
   logic       brush;
   logic [7:0] wx;
   logic [7:0] wy;
   logic [2:0] newColor;
   logic       done;

   int vecs;
   int miscompares;

   int         wcnt   [0:127][0:127];
   logic [2:0] canvas [0:127][0:127];

   brush_stamper #(.CANVAS_MAX(128), .CW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_clear (cmd_clear),
      .cmd_cx    (cmd_cx),
      .cmd_cy    (cmd_cy),
      .cmd_size  (cmd_size),
      .cmd_color (cmd_color),
      .brush     (brush),
      .wx        (wx),
      .wy        (wy),
      .newColor  (newColor),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input logic [31:0] got, input logic [31:0] exp, input string tag);
      vecs++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clearScoreboard();
      for (int x = 0; x < 128; x++)
         for (int y = 0; y < 128; y++)
            wcnt[x][y] = 0;
   endtask

   // Issues one command and follows it to completion, checking every write
   // against the expected raster window and the done/ready timing.
   task automatic applyStimulus(input logic clr, input int cx, input int cy,
                                input logic [1:0] sz, input logic [2:0] col,
                                input bit exp_empty, input int ex0, input int ex1,
                                input int ey0, input int ey1, input string tag);
      int n_exp;
      int n;
      int done_cyc;
      int ex;
      int ey;
      int order_err;
      int ready_err;
      int wait_cyc;
      logic [2:0] exp_col;
      n_exp     = exp_empty ? 0 : (ex1 - ex0 + 1) * (ey1 - ey0 + 1);
      exp_col   = clr ? ERASE_COLOR : col;
      n         = 0;
      done_cyc  = -1;
      ex        = ex0;
      ey        = ey0;
      order_err = 0;
      ready_err = 0;
      wait_cyc  = 0;
      while (cmd_ready !== 1'b1 && wait_cyc < 50) begin
         @(negedge clk);
         wait_cyc++;
      end
      checkOutput(cmd_ready, 1, {tag, "_ready_before"});
      cmd_valid = 1'b1;
      cmd_clear = clr;
      cmd_cx    = cx[7:0];
      cmd_cy    = cy[7:0];
      cmd_size  = sz;
      cmd_color = col;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_clear = 1'b0;
      cmd_cx    = 8'hAA;
      cmd_cy    = 8'h55;
      cmd_size  = 2'd3;
      cmd_color = ~col;
      for (int cyc = 1; cyc <= 17000; cyc++) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0) ready_err++;
         if (brush === 1'b1) begin
            if (wx !== ex[7:0] || wy !== ey[7:0] || newColor !== exp_col) order_err++;
            if (wx < 128 && wy < 128) begin
               wcnt[wx][wy]++;
               canvas[wx][wy] = newColor;
            end else begin
               order_err++;
            end
            n++;
            if (ex == ex1) begin
               ex = ex0;
               ey++;
            end else begin
               ex++;
            end
         end
         if (done === 1'b1) begin
            if (brush !== 1'b0) order_err++;
            done_cyc = cyc;
            break;
         end
      end
      checkOutput(n, n_exp, {tag, "_writes"});
      checkOutput(done_cyc, n_exp + 1, {tag, "_done_cycle"});
      checkOutput(order_err, 0, {tag, "_raster"});
      checkOutput(ready_err, 0, {tag, "_ready_busy"});
      @(negedge clk);
      checkOutput(done, 0, {tag, "_done_single"});
      checkOutput(cmd_ready, 1, {tag, "_ready_after"});
   endtask

   initial begin
      int total;
      int bad;
      vecs        = 0;
      miscompares = 0;
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_clear   = 1'b0;
      cmd_cx      = '0;
      cmd_cy      = '0;
      cmd_size    = '0;
      cmd_color   = '0;
      clearScoreboard();
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      checkOutput(cmd_ready, 1, "rst_ready");
      checkOutput(brush, 0, "rst_brush");
      checkOutput({wx, wy}, 16'h0000, "rst_wxy");
      checkOutput(newColor, ERASE_COLOR, "rst_color");
      checkOutput(done, 0, "rst_done");
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] single pixel stamp");
      applyStimulus(1'b0, 10, 20, R1, COLOR_RED, 1'b0, 10, 10, 20, 20, "t1");

      $display("[TB] 7x7 clipped at origin");
      applyStimulus(1'b0, 0, 0, R7, COLOR_GREEN, 1'b0, 0, 3, 0, 3, "t2");

      $display("[TB] 3x3 clipped at right edge");
      applyStimulus(1'b0, 127, 64, R3, COLOR_BLUE, 1'b0, 126, 127, 63, 65, "t3");

      $display("[TB] off-canvas centre");
      applyStimulus(1'b0, 200, 5, R1, COLOR_RED, 1'b1, 0, 0, 0, 0, "t4");

      total = 0;
      for (int x = 0; x < 128; x++)
         for (int y = 0; y < 128; y++)
            total += wcnt[x][y];
      checkOutput(total, 23, "stamp_total_writes");
      checkOutput(canvas[10][20], COLOR_RED, "t1_pixel");
      checkOutput(canvas[127][65], COLOR_BLUE, "t3_corner");
      checkOutput(wcnt[4][0], 0, "t2_outside");

      $display("[TB] full clear");
      clearScoreboard();
      applyStimulus(1'b1, 3, 3, R5, COLOR_GREEN, 1'b0, 0, 127, 0, 127, "t5");
      bad = 0;
      for (int x = 0; x < 128; x++)
         for (int y = 0; y < 128; y++)
            if (wcnt[x][y] != 1 || canvas[x][y] !== ERASE_COLOR) bad++;
      checkOutput(bad, 0, "t5_coverage");

      $display("[TB] reset during 5x5 stamp");
      cmd_valid = 1'b1;
      cmd_cx    = 8'd50;
      cmd_cy    = 8'd50;
      cmd_size  = R5;
      cmd_color = COLOR_BLUE;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput(brush, 1, "t6_mid_brush");
      checkOutput({wx, wy}, {8'd52, 8'd48}, "t6_mid_wxy");
      reset = 1'b1;
      @(negedge clk);
      checkOutput(brush, 0, "t6_rst_brush");
      checkOutput({wx, wy}, 16'h0000, "t6_rst_wxy");
      checkOutput(newColor, ERASE_COLOR, "t6_rst_color");
      checkOutput(done, 0, "t6_rst_done");
      checkOutput(cmd_ready, 1, "t6_rst_ready");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 5, 6, R3, COLOR_GREEN, 1'b0, 4, 6, 5, 7, "t6_after");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
